// File: rtl/hfu_pkg.sv
// Shared types and helpers for hazard_forward_unit.
// HFU_ZERO_REG_EN: when defined, register 0 never forwards or stalls.
package hfu_pkg;

  // Records carry rd at a fixed width; REG_AW of the unit must not exceed it.
  localparam int HFU_REC_AW  = 8;
  localparam int SEL_REGFILE = 0;

`ifdef HFU_ZERO_REG_EN
  localparam bit HFU_ZERO_REG = 1'b1;
`else
  localparam bit HFU_ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic                  valid;
    logic [HFU_REC_AW-1:0] rd;
    logic                  wr;
    logic                  ld;
  } hfu_rec_t;

  function automatic int hfu_sel_w(input int fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/hfu_match.sv
// One forwarding-select lane: youngest post-EX writer of rs wins.
// HFU_ZERO_REG_EN (via hfu_pkg) masks register 0.
module hfu_match
  import hfu_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            rs,
  input  hfu_rec_t [FWD_STAGES:1]      post,
  output logic [SEL_W-1:0]             sel
);

  logic rs_ok;
  assign rs_ok = !HFU_ZERO_REG || (rs != '0);

  // Scan oldest to youngest so the youngest hit overwrites; a not-yet-ready
  // load as youngest writer must yield the register file, never stale data.
  always_comb begin
    sel = SEL_W'(SEL_REGFILE);
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (rs_ok && post[k].valid && post[k].wr && post[k].rd == HFU_REC_AW'(rs))
        sel = (post[k].ld && k < LOAD_READY) ? SEL_W'(SEL_REGFILE) : SEL_W'(k);
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow pipeline of destination records driving EX forwarding and ID load-use stall.
// HFU_ZERO_REG_EN (via hfu_pkg) makes register 0 never match.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         id_valid,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]               id_rs,
  input  logic [NUM_SRC-1:0]                           id_rs_used,
  input  logic [REG_AW-1:0]                            id_rd,
  input  logic                                         id_reg_write,
  input  logic                                         id_is_load,
  input  logic                                         flush,
  input  logic                                         hold,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]               ex_rs,
  output logic [NUM_SRC-1:0][hfu_sel_w(FWD_STAGES)-1:0] fwd_sel,
  output logic                                         stall,
  output logic [CNT_W-1:0]                             stall_cnt
);

  localparam int SEL_W = hfu_sel_w(FWD_STAGES);

  // stg[0] is EX, stg[k] is post-EX stage k
  hfu_rec_t [FWD_STAGES:0] stg;
  hfu_rec_t                id_rec;
  logic                    stall_hit;

  // A load at stage k reaches stage k+1 when its dependent reaches EX;
  // stall while that is still short of LOAD_READY.
  always_comb begin
    stall_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        if (k + 1 < LOAD_READY && id_rs_used[i] &&
            (!HFU_ZERO_REG || id_rs[i] != '0) &&
            stg[k].valid && stg[k].ld && stg[k].wr &&
            stg[k].rd == HFU_REC_AW'(id_rs[i]))
          stall_hit = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~hold & stall_hit;

  always_comb begin
    id_rec       = '0;
    id_rec.valid = id_valid & ~stall & ~flush;
    id_rec.rd    = HFU_REC_AW'(id_rd);
    id_rec.wr    = id_reg_write;
    id_rec.ld    = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else if (!hold) begin
      stg[0] <= id_rec;
      for (int k = 1; k <= FWD_STAGES; k++) stg[k] <= stg[k-1];
    end else if (flush) begin
      stg[0].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    hfu_match #(
      .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES),
      .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match (
      .rs  (ex_rs[g]),
      .post(stg[FWD_STAGES:1]),
      .sel (fwd_sel[g])
    );
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: instruction-level model, directed hazards, random traffic.
module tb_hazard_forward_unit;
  import hfu_pkg::*;

  localparam int REG_AW = 3, NUM_SRC = 2, FS = 2, LR = 2, CNT_W = 16, SEL_W = 2;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             id_valid = 1'b0;
  logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs = '0;
  logic [NUM_SRC-1:0]               id_rs_used = '0;
  logic [REG_AW-1:0]                id_rd = '0;
  logic                             id_reg_write = 1'b0;
  logic                             id_is_load = 1'b0;
  logic                             flush = 1'b0;
  logic                             hold = 1'b0;
  logic [NUM_SRC-1:0][REG_AW-1:0]   ex_rs = '0;
  logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel;
  logic                             stall;
  logic [CNT_W-1:0]                 stall_cnt;

  hazard_forward_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FS),
    .LOAD_READY(LR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .hold(hold), .ex_rs(ex_rs),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit [1:0] used; int rs0, rs1, rd; bit wr, ld, fl, hd; int ex0, ex1;
  } stim_t;
  typedef struct { bit v; int rd; bit wr; bit ld; } ins_t;
  typedef struct { int f0, f1; bit st; int cnt; } exp_t;

  ins_t  pipe[$];   // in-flight instructions, [0] = EX, [k] = k stages past EX
  exp_t  exp_q[$];
  stim_t cur;
  bit    cur_stall;
  int    cnt_m;
  int    n_chk = 0, n_fail = 0;

  function automatic bit zero_blk(int a);
`ifdef HFU_ZERO_REG_EN
    return a == 0;
`else
    return (a < 0);
`endif
  endfunction

  // Youngest in-flight writer of rs supplies the value, unless its data is not yet usable.
  function automatic int ref_fwd(int rs);
    if (zero_blk(rs)) return 0;
    for (int k = 1; k <= FS; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == rs)
        return (pipe[k].ld && k < LR) ? 0 : k;
    return 0;
  endfunction

  // Stall when a used source waits on a load that would still be short of readiness next cycle.
  function automatic bit ref_stall(stim_t s);
    if (!s.v || s.hd) return 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int rs = (i == 0) ? s.rs0 : s.rs1;
      if (s.used[i] && !zero_blk(rs))
        for (int k = 0; k <= FS; k++)
          if (k + 1 < LR && pipe[k].v && pipe[k].ld && pipe[k].wr && pipe[k].rd == rs)
            return 1;
    end
    return 0;
  endfunction

  function automatic stim_t mk(bit v, int rd, bit wr, bit ld, int rs0, int rs1,
                               bit [1:0] used, int ex0, int ex1, bit fl = 0, bit hd = 0);
    stim_t s;
    s.v = v; s.rd = rd; s.wr = wr; s.ld = ld; s.rs0 = rs0; s.rs1 = rs1;
    s.used = used; s.ex0 = ex0; s.ex1 = ex1; s.fl = fl; s.hd = hd;
    return s;
  endfunction

  task automatic check(string nm, int act, int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic advance_model();
    ins_t n;
    if (!rst_n) begin
      pipe.delete();
      for (int k = 0; k <= FS; k++) begin n = '{0, 0, 0, 0}; pipe.push_back(n); end
      cnt_m = 0;
    end else begin
      if (cur_stall && cnt_m != (1 << CNT_W) - 1) cnt_m++;
      if (!cur.hd) begin
        n.v = cur.v && !cur_stall && !cur.fl; n.rd = cur.rd; n.wr = cur.wr; n.ld = cur.ld;
        pipe.push_front(n);
        void'(pipe.pop_back());
      end else if (cur.fl) begin
        pipe[0].v = 0;
      end
    end
  endtask

  task automatic issue(stim_t s);
    exp_t e;
    @(posedge clk); #1;
    advance_model();
    rst_n = 1'b1;
    cur = s;
    id_valid = s.v; id_rd = REG_AW'(s.rd); id_reg_write = s.wr; id_is_load = s.ld;
    id_rs[0] = REG_AW'(s.rs0); id_rs[1] = REG_AW'(s.rs1); id_rs_used = s.used;
    ex_rs[0] = REG_AW'(s.ex0); ex_rs[1] = REG_AW'(s.ex1);
    flush = s.fl; hold = s.hd;
    cur_stall = ref_stall(s);
    e.f0 = ref_fwd(s.ex0); e.f1 = ref_fwd(s.ex1); e.st = cur_stall; e.cnt = cnt_m;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_fwd0", fwd_sel[0], 0);
    check("rst_fwd1", fwd_sel[1], 0);
    check("rst_stall", stall, 0);
    check("rst_cnt", stall_cnt, 0);
    exp_q.delete();
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur_stall = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_fwd0", fwd_sel[0], e.f0);
        check("sb_fwd1", fwd_sel[1], e.f1);
        check("sb_stall", stall, e.st);
        check("sb_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin : stim
    stim_t nop, s;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur = nop; cur_stall = 0; cnt_m = 0;
    #2;
    check("init_stall", stall, 0);
    check("init_cnt", stall_cnt, 0);

    // ALU chain on r1
    issue(mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 5, 1, 0, 1, 0, 2'b01, 0, 0));
    issue(mk(1, 6, 1, 0, 1, 0, 2'b01, 1, 0));
    @(negedge clk); check("alu_dist1", fwd_sel[0], 1);
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); check("alu_dist2", fwd_sel[0], 2);

    // Two writers of r1 in flight: stage 1 wins
    issue(mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    issue(nop);
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); check("youngest_wins", fwd_sel[0], 1);

    // Load r2, dependent on source 1
    issue(mk(1, 2, 1, 1, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 7, 1, 0, 0, 2, 2'b10, 0, 0));
    @(negedge clk); check("lu_stall", stall, 1);
    issue(mk(1, 7, 1, 0, 0, 2, 2'b10, 0, 0));
    @(negedge clk); check("lu_stall_once", stall, 0);
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2));
    @(negedge clk); check("lu_fwd1", fwd_sel[1], 2);
    check("lu_cnt", stall_cnt, 1);

    // Load r3 with hold over the would-be stall
    issue(mk(1, 3, 1, 1, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 4, 1, 0, 3, 0, 2'b01, 0, 0, 0, 1));
    @(negedge clk); check("hold_nostall", stall, 0);
    issue(mk(1, 4, 1, 0, 3, 0, 2'b01, 0, 0, 0, 1));
    issue(mk(1, 4, 1, 0, 3, 0, 2'b01, 0, 0));
    @(negedge clk); check("hold_release_stall", stall, 1);
    issue(mk(1, 4, 1, 0, 3, 0, 2'b01, 0, 0));
    @(negedge clk); check("hold_stall_once", stall, 0);
    check("hold_cnt", stall_cnt, 2);

    // Flush kills the load as it enters EX
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 6, 1, 1, 0, 0, 2'b00, 0, 0, 1, 0));
    issue(mk(1, 5, 1, 0, 6, 0, 2'b01, 0, 0));
    @(negedge clk); check("flush_nostall", stall, 0);
    issue(nop);
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 6, 6));
    @(negedge clk); check("flush_nofwd", fwd_sel[0], 0);

    // Register 0 behaviour
    issue(mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    issue(nop);
    issue(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 7));
`ifdef HFU_ZERO_REG_EN
    @(negedge clk); check("r0_fwd", fwd_sel[0], 0);
`else
    @(negedge clk); check("r0_fwd", fwd_sel[0], 1);
`endif

    // Mid-stream reset with records populated
    issue(mk(1, 2, 1, 1, 0, 0, 2'b00, 0, 0));
    issue(mk(1, 1, 1, 0, 2, 0, 2'b01, 0, 0));
    pulse_reset();

    // Random traffic with small register space to force hazards
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        pulse_reset();
        continue;
      end
      if (cur_stall && $urandom_range(0, 3) != 0) s = cur;
      else begin
        s.v = ($urandom_range(0, 9) != 0);
        s.rd = $urandom_range(0, 3); s.wr = ($urandom_range(0, 4) != 0);
        s.ld = ($urandom_range(0, 2) == 0);
        s.rs0 = $urandom_range(0, 3); s.rs1 = $urandom_range(0, 3);
        s.used = 2'($urandom_range(0, 3));
      end
      s.fl = ($urandom_range(0, 9) == 0);
      s.hd = ($urandom_range(0, 9) == 0);
      s.ex0 = $urandom_range(0, 3); s.ex1 = $urandom_range(0, 3);
      issue(s);
    end

    @(negedge clk); @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
